// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store alignment unit.
//   - RV32I load/store FUNCT3 codes
//   - FSM state type (IDLE / SECOND)
//   - access size decode, byte-lane mask and legality helpers
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } lsu_state_e;

  // Access size in bytes (1, 2 or 4) from FUNCT3[1:0].
  function automatic logic [2:0] size_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Byte-enable pattern of an access before it is shifted to its lane offset.
  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // BU/HU exist only as loads; 011, 110 and 111 are never valid.
  function automatic logic f3_valid(input logic [2:0] f3, input logic is_store);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !is_store;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// lsu_load_ext: picks the low byte/halfword/word of an already right-shifted
// load word and sign- or zero-extends it according to FUNCT3.
//   data_i   [31:0] load data, addressed byte already in bits [7:0]
//   funct3_i [2:0]  load type (B, H, W, BU, HU)
//   data_o   [31:0] extended load result (0 for any other code)
import lsu_pkg::*;

module lsu_load_ext (
  input  logic [31:0] data_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  always_comb begin
    case (funct3_i)
      F3_B:    data_o = {{24{data_i[7]}}, data_i[7:0]};
      F3_H:    data_o = {{16{data_i[15]}}, data_i[15:0]};
      F3_W:    data_o = data_i;
      F3_BU:   data_o = {24'h0, data_i[7:0]};
      F3_HU:   data_o = {16'h0, data_i[15:0]};
      default: data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_align.sv
// lsu_align: converts byte/halfword/word loads and stores into word-aligned
// memory accesses with byte enables, extends load data, and splits accesses
// that cross a word boundary into two memory cycles.
//   CLK, RST          clock, asynchronous active-low reset
//   MEM_R, MEM_W      load / store request
//   FUNCT3, ADDR      access type and byte address
//   WDATA             right-justified store data
//   M_RDATA           memory read word (combinational from M_ADDR)
//   M_ADDR, M_WDATA   word address and lane-aligned store data to memory
//   M_BE, M_WE        byte enables and write strobe
//   RDATA             extended load result
//   STALL             core must hold PC and inputs this cycle
//   MISALIGN          crossing access suppressed (SPLIT_EN=0)
//   ILLEGAL           bad FUNCT3, BU/HU store, or MEM_R and MEM_W together
//   DBG_STATE         current FSM state (0 IDLE, 1 SECOND)
//
// Stall contract: while STALL=1 the core keeps every input stable; the cycle
// after a STALL=1 cycle is the second half of the split access and is the
// one that delivers RDATA. Live inputs are not looked at in that cycle.
import lsu_pkg::*;

module lsu_align #(
  parameter logic SPLIT_EN = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MEM_R,
  input  logic        MEM_W,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  input  logic [31:0] M_RDATA,
  output logic [31:0] M_ADDR,
  output logic [31:0] M_WDATA,
  output logic [3:0]  M_BE,
  output logic        M_WE,
  output logic [31:0] RDATA,
  output logic        STALL,
  output logic        MISALIGN,
  output logic        ILLEGAL,
  output logic        DBG_STATE
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_hi_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic [3:0]  be_hi_q;
  logic [31:0] wd_hi_q;
  logic        we_q;
  logic        rd_q;
  logic [31:0] hold_q;

  logic [3:0]  mask;
  logic [2:0]  size;
  logic [1:0]  off;
  logic        req, bad_op, crossing, is_idle, go, split;
  logic [31:0] wd_masked;
  logic [7:0]  be_wide;
  logic [63:0] wd_wide;

  logic [31:0] ld_lo, ld_hi, ld_shift, ext_data;
  logic [1:0]  ld_off;
  logic [2:0]  ld_f3;

  assign mask     = size_mask(FUNCT3);
  assign size     = size_bytes(FUNCT3);
  assign off      = ADDR[1:0];
  assign crossing = ({1'b0, size} + {2'b00, off}) > 4'd4;
  assign req      = MEM_R | MEM_W;
  assign bad_op   = (MEM_R & MEM_W) | !f3_valid(FUNCT3, MEM_W);
  assign is_idle  = (state_q == ST_IDLE);

  // Everything combinational is gated by RST so outputs are quiet in reset.
  assign ILLEGAL  = RST & is_idle & req & bad_op;
  assign MISALIGN = RST & is_idle & req & !bad_op & crossing & !SPLIT_EN;
  assign go       = RST & is_idle & req & !bad_op & !(crossing & !SPLIT_EN);
  assign split    = go & crossing;

  // Low 8*size bits of WDATA, then shifted to the byte lane; bits [63:32]
  // and be_wide[7:4] belong to the following word.
  assign wd_masked = WDATA & {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
  assign be_wide   = {4'b0000, mask} << off;
  assign wd_wide   = {32'h0, wd_masked} << {off, 3'b000};

  assign DBG_STATE = state_q;

  // Load path: the extension unit is shared by single and split accesses;
  // a split load sees {second word, held first word}.
  always_comb begin
    ld_lo  = M_RDATA;
    ld_hi  = 32'h0;
    ld_off = off;
    ld_f3  = FUNCT3;
    if (state_q == ST_SECOND) begin
      ld_lo  = hold_q;
      ld_hi  = M_RDATA;
      ld_off = off_q;
      ld_f3  = f3_q;
    end
    ld_shift = 32'({ld_hi, ld_lo} >> {ld_off, 3'b000});
  end

  lsu_load_ext u_ext (
    .data_i   (ld_shift),
    .funct3_i (ld_f3),
    .data_o   (ext_data)
  );

  always_comb begin
    state_d = state_q;
    M_ADDR  = {ADDR[31:2], 2'b00};
    M_WDATA = wd_wide[31:0];
    M_BE    = 4'b0000;
    M_WE    = 1'b0;
    STALL   = 1'b0;
    RDATA   = 32'h0;
    if (state_q == ST_SECOND) begin
      M_ADDR  = addr_hi_q;
      M_WDATA = wd_hi_q;
      state_d = ST_IDLE;
      if (RST) begin
        M_BE  = be_hi_q;
        M_WE  = we_q & (|be_hi_q);
        RDATA = rd_q ? ext_data : 32'h0;
      end
    end else if (go) begin
      M_BE  = be_wide[3:0];
      M_WE  = MEM_W & (|be_wide[3:0]);
      STALL = split;
      // First half of a split load has no valid result yet.
      RDATA = (MEM_R & !crossing) ? ext_data : 32'h0;
      if (split) state_d = ST_SECOND;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      addr_hi_q <= 32'h0;
      off_q     <= 2'b00;
      f3_q      <= 3'b000;
      be_hi_q   <= 4'b0000;
      wd_hi_q   <= 32'h0;
      we_q      <= 1'b0;
      rd_q      <= 1'b0;
      hold_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      if (split) begin
        addr_hi_q <= {ADDR[31:2], 2'b00} + 32'd4;
        off_q     <= off;
        f3_q      <= FUNCT3;
        be_hi_q   <= be_wide[7:4];
        wd_hi_q   <= wd_wide[63:32];
        we_q      <= MEM_W;
        rd_q      <= MEM_R;
        hold_q    <= M_RDATA;
      end
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
// tb_lsu_align: drives lsu_align (SPLIT_EN=1) and a SPLIT_EN=0 copy with
// directed and random accesses against a byte-array memory model.
module tb_lsu_align;

  logic        CLK, RST, MEM_R, MEM_W;
  logic [2:0]  FUNCT3;
  logic [31:0] ADDR, WDATA;

  logic [31:0] m_rdata, m_addr, m_wdata, rdata;
  logic [3:0]  m_be;
  logic        m_we, stall, misalign, illegal, dbg_state;

  logic [31:0] m_rdata0, m_addr0, m_wdata0, rdata0;
  logic [3:0]  m_be0;
  logic        m_we0, stall0, misalign0, illegal0, dbg_state0;

  logic [31:0] mem [64];     // memory seen by the SPLIT_EN=1 DUT
  logic [7:0]  ref_mem [256]; // reference byte memory
  logic [31:0] exp_q [$];
  int          total = 0;
  int          bad   = 0;

  assign m_rdata  = mem[m_addr[7:2]];
  assign m_rdata0 = mem[m_addr0[7:2]];

  lsu_align #(.SPLIT_EN(1'b1)) u_dut (
    .CLK(CLK), .RST(RST), .MEM_R(MEM_R), .MEM_W(MEM_W), .FUNCT3(FUNCT3),
    .ADDR(ADDR), .WDATA(WDATA), .M_RDATA(m_rdata), .M_ADDR(m_addr),
    .M_WDATA(m_wdata), .M_BE(m_be), .M_WE(m_we), .RDATA(rdata),
    .STALL(stall), .MISALIGN(misalign), .ILLEGAL(illegal), .DBG_STATE(dbg_state)
  );

  lsu_align #(.SPLIT_EN(1'b0)) u_dut0 (
    .CLK(CLK), .RST(RST), .MEM_R(MEM_R), .MEM_W(MEM_W), .FUNCT3(FUNCT3),
    .ADDR(ADDR), .WDATA(WDATA), .M_RDATA(m_rdata0), .M_ADDR(m_addr0),
    .M_WDATA(m_wdata0), .M_BE(m_be0), .M_WE(m_we0), .RDATA(rdata0),
    .STALL(stall0), .MISALIGN(misalign0), .ILLEGAL(illegal0), .DBG_STATE(dbg_state0)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Memory writes from the SPLIT_EN=1 DUT
  always @(posedge CLK) begin
    if (m_we) begin
      for (int b = 0; b < 4; b++)
        if (m_be[b]) mem[m_addr[7:2]][8*b +: 8] <= m_wdata[8*b +: 8];
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sz_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic legal_op(input logic r, input logic w, input logic [2:0] f3);
    if (r && w) return 1'b0;
    if (!r && !w) return 1'b0;
    if (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) return 1'b1;
    if (r && (f3 == 3'd4 || f3 == 3'd5)) return 1'b1;
    return 1'b0;
  endfunction

  // Little-endian gather of sz bytes, then extension by plain arithmetic.
  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
    int          sz;
    logic [31:0] v;
    logic [7:0]  bi;
    sz = sz_of(f3);
    v  = 32'h0;
    for (int i = 0; i < sz; i++) begin
      bi = 8'(a + 32'(i));
      v  = v | (32'(ref_mem[bi]) << (8 * i));
    end
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
    return v;
  endfunction

  function automatic logic [31:0] ref_word(input int w);
    return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    for (int i = 0; i < 4; i++) ref_mem[{a[7:2], 2'(i)}] = v[8*i +: 8];
    mem[a[7:2]] = v;
  endtask

  task automatic set_idle();
    MEM_R = 1'b0; MEM_W = 1'b0; FUNCT3 = 3'b010; ADDR = 32'h0; WDATA = 32'h0;
  endtask

  // ---------------- driver ----------------
  task automatic issue(input logic r, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    int         sz;
    logic [7:0] bi;
    sz = sz_of(f3);
    if (legal_op(r, w, f3)) begin
      if (r) exp_q.push_back(ref_load(a, f3));
      if (w)
        for (int i = 0; i < sz; i++) begin
          bi = 8'(a + 32'(i));
          ref_mem[bi] = wd[8*i +: 8];
        end
    end
    MEM_R = r; MEM_W = w; FUNCT3 = f3; ADDR = a; WDATA = wd;
  endtask

  function automatic logic crosses(input logic [31:0] a, input logic [2:0] f3);
    return (int'(a[1:0]) + sz_of(f3)) > 4;
  endfunction

  // Called at a negedge of the first access cycle; counts cycles until STALL drops.
  task automatic complete(input int exp_n);
    int n;
    n = 1;
    while (stall === 1'b1 && n < 3) begin
      @(posedge CLK);
      @(negedge CLK);
      n++;
    end
    chk("stall_cycles", 32'(n), 32'(exp_n));
    @(posedge CLK);
    #1;
    set_idle();
  endtask

  task automatic access(input logic r, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    logic lg, cr;
    lg = legal_op(r, w, f3);
    cr = crosses(a, f3);
    issue(r, w, f3, a, wd);
    @(negedge CLK);
    chk("illegal", {31'h0, illegal}, {31'h0, !lg});
    chk("misalign_nosplit", {31'h0, misalign0}, {31'h0, lg && cr});
    if (!lg) begin
      @(posedge CLK);
      #1;
      set_idle();
    end else begin
      complete(cr ? 2 : 1);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge CLK) begin
    if (RST && MEM_R && !MEM_W && !stall && !illegal) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rdata_unexpected: got %h with no load outstanding", rdata);
      end else begin
        chk("rdata", rdata, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a, wd;
    logic [2:0]  f3;
    logic        r, w;
    int          sel;
    logic [2:0]  ld_codes [5];
    logic [31:0] orig_hi;

    ld_codes[0] = 3'd0; ld_codes[1] = 3'd1; ld_codes[2] = 3'd2;
    ld_codes[3] = 3'd4; ld_codes[4] = 3'd5;

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    for (int i = 0; i < 64; i++) mem[i] = ref_word(i);

    // Reset with a crossing store held on the inputs
    RST = 1'b0;
    MEM_R = 1'b0; MEM_W = 1'b1; FUNCT3 = 3'b010; ADDR = 32'h43; WDATA = 32'h1234_5678;
    #12;
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_we", {31'h0, m_we}, 32'h0);
    chk("rst_be", {28'h0, m_be}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_misalign", {31'h0, misalign0}, 32'h0);
    chk("rst_illegal", {31'h0, illegal}, 32'h0);
    chk("rst_state", {31'h0, dbg_state}, 32'h0);
    set_idle();
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;

    // LW aligned
    set_word(32'h10, 32'hDEAD_BEEF);
    issue(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    @(negedge CLK);
    chk("lw_addr", m_addr, 32'h10);
    chk("lw_be", {28'h0, m_be}, 32'hF);
    chk("lw_rdata", rdata, 32'hDEAD_BEEF);
    complete(1);

    // LB / LBU on the top byte
    set_word(32'h10, 32'h80FF_1234);
    issue(1'b1, 1'b0, 3'b000, 32'h13, 32'h0);
    @(negedge CLK);
    chk("lb_be", {28'h0, m_be}, 32'h8);
    chk("lb_rdata", rdata, 32'hFFFF_FF80);
    complete(1);
    issue(1'b1, 1'b0, 3'b100, 32'h13, 32'h0);
    @(negedge CLK);
    chk("lbu_rdata", rdata, 32'h0000_0080);
    complete(1);

    // SH with junk in the upper store bits
    issue(1'b0, 1'b1, 3'b001, 32'h22, 32'h5555_ABCD);
    @(negedge CLK);
    chk("sh_addr", m_addr, 32'h20);
    chk("sh_be", {28'h0, m_be}, 32'hC);
    chk("sh_wdata", m_wdata, 32'hABCD_0000);
    chk("sh_we", {31'h0, m_we}, 32'h1);
    complete(1);

    // Split SW at 0x43, then read it back
    issue(1'b0, 1'b1, 3'b010, 32'h43, 32'h1122_3344);
    @(negedge CLK);
    chk("sw1_addr", m_addr, 32'h40);
    chk("sw1_be", {28'h0, m_be}, 32'h8);
    chk("sw1_wdata", m_wdata, 32'h4400_0000);
    chk("sw1_stall", {31'h0, stall}, 32'h1);
    @(posedge CLK);
    @(negedge CLK);
    chk("sw2_addr", m_addr, 32'h44);
    chk("sw2_be", {28'h0, m_be}, 32'h7);
    chk("sw2_wdata", m_wdata, 32'h0011_2233);
    chk("sw2_stall", {31'h0, stall}, 32'h0);
    @(posedge CLK);
    #1;
    set_idle();
    issue(1'b1, 1'b0, 3'b010, 32'h43, 32'h0);
    @(negedge CLK);
    chk("lw_split_stall", {31'h0, stall}, 32'h1);
    @(posedge CLK);
    @(negedge CLK);
    chk("lw_split_rdata", rdata, 32'h1122_3344);
    @(posedge CLK);
    #1;
    set_idle();

    // Address wrap: word store at 0xFFFFFFFD
    issue(1'b0, 1'b1, 3'b010, 32'hFFFF_FFFD, 32'hCAFE_F00D);
    @(negedge CLK);
    chk("wrap1_addr", m_addr, 32'hFFFF_FFFC);
    chk("wrap1_be", {28'h0, m_be}, 32'hE);
    chk("wrap1_wdata", m_wdata, 32'hFEF0_0D00);
    @(posedge CLK);
    @(negedge CLK);
    chk("wrap2_addr", m_addr, 32'h0);
    chk("wrap2_be", {28'h0, m_be}, 32'h1);
    chk("wrap2_wdata", m_wdata, 32'h0000_00CA);
    @(posedge CLK);
    #1;
    set_idle();

    // SPLIT_EN=0: crossing LH flagged and suppressed (SPLIT_EN=1 copy splits)
    issue(1'b1, 1'b0, 3'b001, 32'h07, 32'h0);
    @(negedge CLK);
    chk("mis_flag", {31'h0, misalign0}, 32'h1);
    chk("mis_be", {28'h0, m_be0}, 32'h0);
    chk("mis_stall", {31'h0, stall0}, 32'h0);
    chk("mis_we", {31'h0, m_we0}, 32'h0);
    complete(2);

    // Illegal requests
    issue(1'b1, 1'b0, 3'b011, 32'h10, 32'h0);
    @(negedge CLK);
    chk("ill_f3", {31'h0, illegal}, 32'h1);
    chk("ill_f3_be", {28'h0, m_be}, 32'h0);
    chk("ill_f3_rdata", rdata, 32'h0);
    @(posedge CLK); #1;
    issue(1'b1, 1'b1, 3'b000, 32'h11, 32'hFF);
    @(negedge CLK);
    chk("ill_rw", {31'h0, illegal}, 32'h1);
    chk("ill_rw_we", {31'h0, m_we}, 32'h0);
    @(posedge CLK); #1;
    issue(1'b0, 1'b1, 3'b101, 32'h12, 32'hFFFF);
    @(negedge CLK);
    chk("ill_hu_store", {31'h0, illegal}, 32'h1);
    chk("ill_hu_stall", {31'h0, stall}, 32'h0);
    @(posedge CLK); #1;
    set_idle();

    // Reset during SECOND of a split store at 0x83
    orig_hi = ref_word(32'h84 >> 2);
    MEM_R = 1'b0; MEM_W = 1'b1; FUNCT3 = 3'b010; ADDR = 32'h83; WDATA = 32'hA5A5_5A5A;
    @(negedge CLK);
    chk("rstsec_stall1", {31'h0, stall}, 32'h1);
    @(posedge CLK);
    #1;
    chk("rstsec_state", {31'h0, dbg_state}, 32'h1);
    RST = 1'b0;
    #1;
    chk("rstsec_state_after", {31'h0, dbg_state}, 32'h0);
    chk("rstsec_stall", {31'h0, stall}, 32'h0);
    chk("rstsec_we", {31'h0, m_we}, 32'h0);
    chk("rstsec_be", {28'h0, m_be}, 32'h0);
    ref_mem[8'h83] = 8'h5A;
    @(negedge CLK);
    set_idle();
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk("rstsec_lo_word", mem[32'h80 >> 2], ref_word(32'h80 >> 2));
    chk("rstsec_hi_word", mem[32'h84 >> 2], orig_hi);
    access(1'b0, 1'b1, 3'b010, 32'h90, 32'h0BAD_F00D);
    access(1'b1, 1'b0, 3'b010, 32'h90, 32'h0);

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      sel = $urandom_range(0, 15);
      a   = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 255));
      wd  = $urandom();
      if (sel == 0) begin
        r = 1'b1; w = 1'b1; f3 = 3'($urandom_range(0, 2));
      end else if (sel == 1) begin
        r = 1'b1; w = 1'b0; f3 = 3'b011;
      end else if (sel < 9) begin
        r = 1'b1; w = 1'b0; f3 = ld_codes[$urandom_range(0, 4)];
      end else begin
        r = 1'b0; w = 1'b1; f3 = 3'($urandom_range(0, 2));
      end
      access(r, w, f3, a, wd);
    end

    // Final report
    @(negedge CLK);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    for (int i = 0; i < 64; i++) chk("mem_word", mem[i], ref_word(i));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_align.md
# lsu_align

Load/store alignment unit between the ALU/control path and the word-addressed data memory of the single-cycle RISC-V core. It converts byte/halfword/word accesses (RV32I funct3 encoding) into aligned word accesses with byte enables, sign/zero-extends load data, and splits boundary-crossing misaligned accesses into two memory cycles, stalling the core for one cycle.

## Interface
Parameters:
- SPLIT_EN, 1, 1: split crossing accesses in two cycles; 0: flag them as MISALIGN and suppress the access

Ports:
- CLK  in  1  core clock
- RST  in  1  asynchronous, active-low reset
- MEM_R  in  1  load request
- MEM_W  in  1  store request
- FUNCT3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
- ADDR  in  32  byte address (ALU result)
- WDATA  in  32  store data (RD2), right-justified
- M_RDATA  in  32  memory read word, combinational from M_ADDR
- M_ADDR  out  32  word-aligned memory address
- M_WDATA  out  32  lane-aligned store data
- M_BE  out  4  byte enables
- M_WE  out  1  memory write strobe
- RDATA  out  32  extended load result
- STALL  out  1  core must hold PC/inputs this cycle
- MISALIGN  out  1  crossing access with SPLIT_EN=0
- ILLEGAL  out  1  bad FUNCT3, BU/HU store, or MEM_R&MEM_W

## Operation
- size = 1/2/4 bytes from FUNCT3[1:0]; off = ADDR[1:0]; crossing = size+off > 4.
- Illegal request: ILLEGAL=1, M_BE=0, M_WE=0, RDATA=0, no state change.
- Lane math: be_wide[7:0] = size_mask << off; wd_wide[63:0] = masked WDATA << 8*off; low word uses [3:0]/[31:0], high word uses [7:4]/[63:32].
- Load result: {hi_word, lo_word} >> 8*off, then low size bytes sign-extended (B, H) or zero-extended (BU, HU, W untouched).
- FSM states IDLE, SECOND.
  - IDLE, non-crossing or no request: single access at {ADDR[31:2],2'b00}, STALL=0, stay IDLE.
  - IDLE, crossing, SPLIT_EN=1: access low word with low BE, STALL=1; at edge capture base+4, off, FUNCT3, high BE, high WDATA lanes, and M_RDATA into HOLD; go SECOND.
  - SECOND: access captured high address with captured high BE/data, M_WE per captured op, STALL=0, RDATA from {M_RDATA, HOLD}; go IDLE at next edge. Live inputs ignored in SECOND.
- Crossing with SPLIT_EN=0: MISALIGN=1, no access, STALL=0.
- Address arithmetic mod 2^32: 0xFFFFFFFD word store touches 0xFFFFFFFC then 0x00000000.
- M_WE=1 only when MEM_W with nonzero BE; loads never assert M_WE.

## Timing
- Reset: state IDLE, HOLD and all captured registers 0; while RST low, STALL=0, M_WE=0, M_BE=0, RDATA=0, MISALIGN=0, ILLEGAL=0.
- Aligned/non-crossing: zero-cycle latency, outputs combinational from inputs.
- Crossing: two cycles, STALL high in first only; RDATA valid in second cycle.
- Memory writes occur on the CLK edge ending each access cycle.
- Reset during SECOND: abort to IDLE; low half of a split store stays written (no rollback).
- MISALIGN/ILLEGAL combinational, never asserted in SECOND.

## Structure
- Package lsu_pkg: FUNCT3 codes, state enum (IDLE, SECOND), size decode and size_mask functions.
- Sub-module lsu_load_ext: combinational byte/half selection and sign/zero extension, reused by both paths.
- FSM, capture registers and lane shifting remain in lsu_align.

## Test plan
- LW at 0x10, mem[0x10]=0xDEADBEEF -> M_ADDR=0x10, BE=1111, RDATA=0xDEADBEEF, STALL=0.
- LB at 0x13, word 0x80FF1234 -> BE=1000, RDATA=0xFFFFFF80; LBU same -> 0x00000080.
- SH 0xABCD at 0x22 -> M_ADDR=0x20, BE=1100, M_WDATA=0xABCD0000, single cycle.
- SW 0x11223344 at 0x43 -> cycle1 M_ADDR=0x40 BE=1000 data 0x44000000 STALL=1; cycle2 M_ADDR=0x44 BE=0111 data 0x00112233; LW at 0x43 reads back 0x11223344 over two cycles.
- SPLIT_EN=0, LH at 0x07 -> MISALIGN=1, BE=0, STALL=0; FUNCT3=011 or SB with MEM_R&MEM_W -> ILLEGAL=1.
- RST low during SECOND of split store -> state IDLE, STALL=0, only low word modified; next access aligned, single cycle.
